// File: rtl/pending_encoder.sv
// Accumulates 8 request lines into a sticky pending register and offers one
// pending index at a time as a registered code with a valid/ack handshake.
module pending_encoder #(
  parameter int LOW_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic       ack,
  output logic [2:0] B,
  output logic       valid,
  output logic [7:0] pending,
  output logic       multi
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] b_q, b_d;
  logic       valid_q, valid_d;
  logic [7:0] clr_mask;

  // Priority encoder; the last matching index in scan order wins.
  function automatic logic [2:0] encode(input logic [7:0] p);
    logic [2:0] enc;
    enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (LOW_FIRST != 0) begin
        if (p[7 - i]) enc = 3'(7 - i);
      end else begin
        if (p[i]) enc = 3'(i);
      end
    end
    return enc;
  endfunction

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_clr
      assign clr_mask[gi] = (b_q == 3'(gi));
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    valid_d   = valid_q;
    pending_d = pending_q | A;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d = OFFER;
          valid_d = 1'b1;
          b_d     = encode(pending_q);
        end
      end
      OFFER: begin
        if (ack) begin
          // OR-ing A after the clear lets a same-cycle re-request keep its bit.
          pending_d = (pending_q & ~clr_mask) | A;
          if (|pending_d) begin
            b_d = encode(pending_d);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 8'h00;
      b_q       <= 3'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      b_q       <= b_d;
      valid_q   <= valid_d;
    end
  end

  assign B       = b_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign multi   = |(pending_q & (pending_q - 8'd1));

endmodule

// File: tb/tb_pending_encoder.sv
// Directed bench for pending_encoder: one instance per priority order, sharing
// the same stimulus; outputs are sampled 1 time unit after the rising edge.
module tb_pending_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] A   = 8'h00;
  logic       ack = 1'b0;

  logic [2:0] lo_b, hi_b;
  logic       lo_valid, hi_valid, lo_multi, hi_multi;
  logic [7:0] lo_pending, hi_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pending_encoder #(.LOW_FIRST(1)) u_lo (
    .clk(clk), .rst(rst), .A(A), .ack(ack),
    .B(lo_b), .valid(lo_valid), .pending(lo_pending), .multi(lo_multi)
  );

  pending_encoder #(.LOW_FIRST(0)) u_hi (
    .clk(clk), .rst(rst), .A(A), .ack(ack),
    .B(hi_b), .valid(hi_valid), .pending(hi_pending), .multi(hi_multi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({lo_valid, lo_b, lo_pending, lo_multi} !== {1'b0, 3'd0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_lo got v=%0b B=%0d p=%h m=%0b want v=0 B=0 p=00 m=0", lo_valid, lo_b, lo_pending, lo_multi);
    end
    checks++;
    if ({hi_valid, hi_b, hi_pending} !== {1'b0, 3'd0, 8'h00}) begin
      errors++;
      $display("FAIL reset_hi got v=%0b B=%0d p=%h want v=0 B=0 p=00", hi_valid, hi_b, hi_pending);
    end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_single();
    A = 8'h20;
    tick();
    A = 8'h00;
    checks++;
    if ({lo_valid, lo_pending} !== {1'b0, 8'h20}) begin
      errors++;
      $display("FAIL single_capture got v=%0b p=%h want v=0 p=20", lo_valid, lo_pending);
    end
    tick();
    checks++;
    if ({lo_valid, lo_b, hi_valid, hi_b} !== {1'b1, 3'd5, 1'b1, 3'd5}) begin
      errors++;
      $display("FAIL single_offer got lo v=%0b B=%0d hi v=%0b B=%0d want 1/5 1/5", lo_valid, lo_b, hi_valid, hi_b);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if ({lo_valid, lo_pending, lo_b} !== {1'b0, 8'h00, 3'd5}) begin
      errors++;
      $display("FAIL single_ack got v=%0b p=%h B=%0d want v=0 p=00 B=5", lo_valid, lo_pending, lo_b);
    end
    $display("single request done");
  endtask

  task automatic test_priority();
    logic [2:0] exp_lo [3];
    logic [2:0] exp_hi [3];
    logic       exp_m  [3];
    exp_lo = '{3'd0, 3'd4, 3'd7};
    exp_hi = '{3'd7, 3'd4, 3'd0};
    exp_m  = '{1'b1, 1'b1, 1'b0};
    A   = 8'h91;
    ack = 1'b1;
    tick();
    A = 8'h00;
    checks++;
    if ({lo_valid, lo_pending, hi_valid, hi_pending} !== {1'b0, 8'h91, 1'b0, 8'h91}) begin
      errors++;
      $display("FAIL prio_capture got lo v=%0b p=%h hi v=%0b p=%h want 0/91 0/91", lo_valid, lo_pending, hi_valid, hi_pending);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({lo_valid, lo_b, lo_multi} !== {1'b1, exp_lo[k], exp_m[k]}) begin
        errors++;
        $display("FAIL prio_lo_%0d got v=%0b B=%0d m=%0b want v=1 B=%0d m=%0b", k, lo_valid, lo_b, lo_multi, exp_lo[k], exp_m[k]);
      end
      checks++;
      if ({hi_valid, hi_b, hi_multi} !== {1'b1, exp_hi[k], exp_m[k]}) begin
        errors++;
        $display("FAIL prio_hi_%0d got v=%0b B=%0d m=%0b want v=1 B=%0d m=%0b", k, hi_valid, hi_b, hi_multi, exp_hi[k], exp_m[k]);
      end
    end
    tick();
    ack = 1'b0;
    checks++;
    if ({lo_valid, lo_pending, hi_valid, hi_pending} !== {1'b0, 8'h00, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL prio_drain got lo v=%0b p=%h hi v=%0b p=%h want 0/00 0/00", lo_valid, lo_pending, hi_valid, hi_pending);
    end
    $display("priority sequences done");
  endtask

  task automatic test_stability();
    A = 8'h08;
    tick();
    A = 8'h00;
    tick();
    A = 8'h01;
    tick();
    A = 8'h00;
    checks++;
    if ({lo_valid, lo_b, lo_pending} !== {1'b1, 3'd3, 8'h09}) begin
      errors++;
      $display("FAIL hold_offer got v=%0b B=%0d p=%h want v=1 B=3 p=09", lo_valid, lo_b, lo_pending);
    end
    tick();
    checks++;
    if ({lo_valid, lo_b} !== {1'b1, 3'd3}) begin
      errors++;
      $display("FAIL hold_offer2 got v=%0b B=%0d want v=1 B=3", lo_valid, lo_b);
    end
    ack = 1'b1;
    A   = 8'h08;
    tick();
    A = 8'h00;
    checks++;
    if ({lo_valid, lo_b, lo_pending} !== {1'b1, 3'd0, 8'h09}) begin
      errors++;
      $display("FAIL set_wins_lo got v=%0b B=%0d p=%h want v=1 B=0 p=09", lo_valid, lo_b, lo_pending);
    end
    checks++;
    if ({hi_valid, hi_b, hi_pending} !== {1'b1, 3'd3, 8'h09}) begin
      errors++;
      $display("FAIL set_wins_hi got v=%0b B=%0d p=%h want v=1 B=3 p=09", hi_valid, hi_b, hi_pending);
    end
    tick();
    checks++;
    if ({lo_valid, lo_b, lo_pending} !== {1'b1, 3'd3, 8'h08}) begin
      errors++;
      $display("FAIL reoffer got v=%0b B=%0d p=%h want v=1 B=3 p=08", lo_valid, lo_b, lo_pending);
    end
    tick();
    ack = 1'b0;
    checks++;
    if ({lo_valid, lo_pending} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL stab_drain got v=%0b p=%h want v=0 p=00", lo_valid, lo_pending);
    end
    $display("stability and set-wins done");
  endtask

  task automatic test_ack_idle();
    ack = 1'b1;
    tick();
    tick();
    ack = 1'b0;
    checks++;
    if ({lo_valid, lo_b, lo_pending} !== {1'b0, 3'd3, 8'h00}) begin
      errors++;
      $display("FAIL ack_idle got v=%0b B=%0d p=%h want v=0 B=3 p=00", lo_valid, lo_b, lo_pending);
    end
    $display("ack in idle done");
  endtask

  task automatic test_absorb();
    A = 8'h04;
    tick();
    tick();
    A = 8'h00;
    checks++;
    if ({lo_valid, lo_b, lo_pending, lo_multi} !== {1'b1, 3'd2, 8'h04, 1'b0}) begin
      errors++;
      $display("FAIL absorb_offer got v=%0b B=%0d p=%h m=%0b want v=1 B=2 p=04 m=0", lo_valid, lo_b, lo_pending, lo_multi);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    checks++;
    if ({lo_valid, lo_pending} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL absorb_no_second got v=%0b p=%h want v=0 p=00", lo_valid, lo_pending);
    end
    $display("duplicate request done");
  endtask

  task automatic test_async_reset();
    A = 8'hFF;
    tick();
    A = 8'h00;
    tick();
    checks++;
    if ({lo_valid, lo_pending} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL arst_setup got v=%0b p=%h want v=1 p=ff", lo_valid, lo_pending);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({lo_valid, lo_b, lo_pending, hi_valid, hi_b, hi_pending} !== {1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00}) begin
      errors++;
      $display("FAIL arst_immediate got lo v=%0b B=%0d p=%h hi v=%0b B=%0d p=%h want all zero", lo_valid, lo_b, lo_pending, hi_valid, hi_b, hi_pending);
    end
    A = 8'h10;
    tick();
    A   = 8'h00;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({lo_valid, lo_pending, hi_valid, hi_pending} !== {1'b0, 8'h00, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL arst_release got lo v=%0b p=%h hi v=%0b p=%h want 0/00 0/00", lo_valid, lo_pending, hi_valid, hi_pending);
    end
    $display("async reset mid-offer done");
  endtask

  task automatic test_exhaustive();
    logic [7:0] v, iso;
    logic [2:0] exp_lo, exp_hi;
    int         bad;
    bad = 0;
    for (int n = 1; n < 256; n++) begin
      v      = 8'(n);
      iso    = v & (~v + 8'd1);
      exp_lo = 3'($clog2(iso));
      exp_hi = 3'($clog2(n + 1) - 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      A   = v;
      tick();
      A = 8'h00;
      tick();
      checks++;
      if ({lo_valid, lo_b, hi_valid, hi_b} !== {1'b1, exp_lo, 1'b1, exp_hi}) begin
        errors++;
        bad++;
        $display("FAIL exhaustive p=%h got lo v=%0b B=%0d hi v=%0b B=%0d want lo B=%0d hi B=%0d", v, lo_valid, lo_b, hi_valid, hi_b, exp_lo, exp_hi);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("exhaustive encode over 255 values, %0d bad", bad);
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_stability();
    test_ack_idle();
    test_absorb();
    test_async_reset();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
